// File: rtl/alu_pkg.sv
// Shared opcode encoding and widths for the registered N-bit ALU.
// ALU_FLAGS_EN (optional) adds registered carry_out/zero/overflow outputs.
package alu_pkg;

    localparam int ALU_OP_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/result bundle between a datapath driver (master) and the ALU (slave).
// Flag signals exist only when ALU_FLAGS_EN is defined.
interface alu_if #(
    parameter int N = 1
);
    import alu_pkg::*;

    logic [N-1:0] operand1;
    logic [N-1:0] operand2;
    alu_op_e      operation;
    logic [N-1:0] result;
`ifdef ALU_FLAGS_EN
    logic         carry_out;
    logic         zero;
    logic         overflow;

    modport master (output operand1, operand2, operation,
                    input  result, carry_out, zero, overflow);
    modport slave  (input  operand1, operand2, operation,
                    output result, carry_out, zero, overflow);
`else
    modport master (output operand1, operand2, operation, input result);
    modport slave  (input  operand1, operand2, operation, output result);
`endif

endinterface

// File: rtl/alu_core.sv
// Combinational ALU stage: next result (and raw flags under ALU_FLAGS_EN) from current inputs.
// Zero latency, no state; the owning module registers every output.
module alu_core
    import alu_pkg::*;
#(
    parameter int N = 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  alu_op_e      op_i,
`ifdef ALU_FLAGS_EN
    output logic         carry_o,
    output logic         zero_o,
    output logic         overflow_o,
`endif
    output logic [N-1:0] next_result_o
);

`ifdef ALU_FLAGS_EN
    // One extra bit holds the carry of ADD and the borrow of SUB.
    logic [N:0] sum_w;
    logic [N:0] diff_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        next_result_o = '0;
        carry_o       = 1'b0;
        overflow_o    = 1'b0;
        case (op_i)
            ALU_ADD: begin
                next_result_o = sum_w[N-1:0];
                carry_o       = sum_w[N];
                overflow_o    = (a_i[N-1] == b_i[N-1]) && (sum_w[N-1] != a_i[N-1]);
            end
            ALU_SUB: begin
                next_result_o = diff_w[N-1:0];
                carry_o       = ~diff_w[N];
                overflow_o    = (a_i[N-1] != b_i[N-1]) && (diff_w[N-1] != a_i[N-1]);
            end
            ALU_AND: next_result_o = a_i & b_i;
            ALU_OR:  next_result_o = a_i | b_i;
            default: next_result_o = '0;
        endcase
    end

    assign zero_o = (next_result_o == '0);
`else
    always_comb begin
        next_result_o = '0;
        case (op_i)
            ALU_ADD: next_result_o = a_i + b_i;
            ALU_SUB: next_result_o = a_i - b_i;
            ALU_AND: next_result_o = a_i & b_i;
            ALU_OR:  next_result_o = a_i | b_i;
            default: next_result_o = '0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_nbit_top.sv
// Registered N-bit ALU: result (and flags under ALU_FLAGS_EN) one cycle after the inputs.
// Accepts a new operation every clock; no handshake. Async active-low reset clears outputs.
module alu_nbit_top
    import alu_pkg::*;
#(
    parameter int N = 1
) (
    input  logic  clk,
    input  logic  reset,
    alu_if.slave  bus
);

    logic [N-1:0] result_d;
    logic [N-1:0] result_q;

`ifdef ALU_FLAGS_EN
    logic carry_d, zero_d, overflow_d;
    logic carry_q, zero_q, overflow_q;
`endif

    alu_core #(.N(N)) u_core (
        .a_i           (bus.operand1),
        .b_i           (bus.operand2),
        .op_i          (bus.operation),
`ifdef ALU_FLAGS_EN
        .carry_o       (carry_d),
        .zero_o        (zero_d),
        .overflow_o    (overflow_d),
`endif
        .next_result_o (result_d)
    );

    // Reset release is assumed already aligned to clk by the reset source.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign bus.result = result_q;

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_alu_nbit_top.sv
// Directed bench for alu_nbit_top at N=1 and N=4, sharing clock and reset.
module tb_alu_nbit_top;
    import alu_pkg::*;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    alu_if #(.N(1)) bus1 ();
    alu_if #(.N(4)) bus4 ();

    alu_nbit_top #(.N(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    alu_nbit_top #(.N(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic drive1(input logic a, input logic b, input alu_op_e op);
        bus1.operand1  = a;
        bus1.operand2  = b;
        bus1.operation = op;
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b, input alu_op_e op);
        bus4.operand1  = a;
        bus4.operand2  = b;
        bus4.operation = op;
    endtask

    task automatic test_reset();
        drive1(1'b1, 1'b1, ALU_ADD);
        drive4(4'd1, 4'd1, ALU_ADD);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        total_cnt++;
        if (bus4.result !== 4'd0) $display("FAIL reset_immediate: got %0d want 0", bus4.result);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (bus4.result !== 4'd0) $display("FAIL reset_hold_%0d: got %0d want 0", i, bus4.result);
            else pass_cnt++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total_cnt++;
        if (bus4.result !== 4'd0) $display("FAIL reset_release_no_edge: got %0d want 0", bus4.result);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'd2) $display("FAIL reset_first_load: got %0d want 2", bus4.result);
        else pass_cnt++;
    endtask

    task automatic test_n1_sequence();
        logic    a_tab [4];
        logic    b_tab [4];
        alu_op_e o_tab [4];
        logic    e_tab [4];
        a_tab = '{1'b0, 1'b1, 1'b1, 1'b1};
        b_tab = '{1'b1, 1'b1, 1'b1, 1'b0};
        o_tab = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR};
        e_tab = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive1(a_tab[i], b_tab[i], o_tab[i]);
            @(posedge clk); #1;
            total_cnt++;
            if (bus1.result !== e_tab[i])
                $display("FAIL n1_op%0d: got %0b want %0b", i, bus1.result, e_tab[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_n4_wrap();
        drive4(4'd15, 4'd1, ALU_ADD);
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'd0) $display("FAIL add_wrap: got %0d want 0", bus4.result);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({bus4.carry_out, bus4.zero, bus4.overflow} !== 3'b110)
            $display("FAIL add_wrap_flags: got %b want 110", {bus4.carry_out, bus4.zero, bus4.overflow});
        else pass_cnt++;
`endif
        drive4(4'd0, 4'd1, ALU_SUB);
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'd15) $display("FAIL sub_wrap: got %0d want 15", bus4.result);
        else pass_cnt++;
`ifdef ALU_FLAGS_EN
        total_cnt++;
        if ({bus4.carry_out, bus4.zero, bus4.overflow} !== 3'b000)
            $display("FAIL sub_wrap_flags: got %b want 000", {bus4.carry_out, bus4.zero, bus4.overflow});
        else pass_cnt++;
`endif
    endtask

    task automatic test_n4_logic();
        drive4(4'b1100, 4'b1010, ALU_AND);
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'b1000) $display("FAIL and4: got %b want 1000", bus4.result);
        else pass_cnt++;
        drive4(4'b1100, 4'b1010, ALU_OR);
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'b1110) $display("FAIL or4: got %b want 1110", bus4.result);
        else pass_cnt++;
    endtask

    // Entered at posedge+1 with result=1110 still held.
    task automatic test_async_reset();
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (bus4.result !== 4'd0) $display("FAIL async_reset: got %b want 0000", bus4.result);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus4.result !== 4'd0) $display("FAIL async_reset_hold: got %b want 0000", bus4.result);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b, exp_q;
        alu_op_e    op;
        exp_q = '0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                total_cnt++;
                if (bus4.result !== exp_q)
                    $display("FAIL b2b_%0d: got %0d want %0d", i, bus4.result, exp_q);
                else pass_cnt++;
            end
            if (i < 16) begin
                a  = 4'($urandom_range(0, 15));
                b  = 4'($urandom_range(0, 15));
                op = alu_op_e'(i % 4);
                drive4(a, b, op);
                case (op)
                    ALU_ADD: exp_q = 4'((int'(a) + int'(b)) % 16);
                    ALU_SUB: exp_q = 4'((int'(a) - int'(b) + 16) % 16);
                    ALU_AND: exp_q = a & b;
                    default: exp_q = a | b;
                endcase
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        test_reset();
        test_n1_sequence();
        test_n4_wrap();
        test_n4_logic();
        test_async_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
